// File: rtl/spi_reg_if.sv
// SPI mode-0 slave front end: decodes one W/addr/data frame per CS_N assertion
// into a single read or write request toward the register bank.
module spi_reg_if #(
  parameter int ADDR_W = 7,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_rdn,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  wdata,
  output logic              we,
  input  logic [REG_W-1:0]  rdata,
  input  logic              ack,
  input  logic              err,
  output logic              err_flag
);
  localparam int CNT_W = $clog2(ADDR_W + REG_W);

  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, DATA, WR_REQ, DONE} state_t;

  state_t             state;
  logic [1:0]         cs_q, sclk_q, mosi_q;
  logic               cs_prev, sclk_prev;
  logic               cs_n_s, mosi_s, rise, fall, start;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  cmd_sh;
  logic [REG_W-2:0]   data_sh;
  logic [REG_W-2:0]   miso_sh;  // bits still to send; MSB goes straight to spi_miso
  logic               is_wr;

  // Synchronisers reset to 0 so a CS_N already low at reset release is not
  // mistaken for a frame start.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cs_q      <= '0;
      sclk_q    <= '0;
      mosi_q    <= '0;
      cs_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      cs_q      <= {cs_q[0], spi_cs_n};
      sclk_q    <= {sclk_q[0], spi_sclk};
      mosi_q    <= {mosi_q[0], spi_mosi};
      cs_prev   <= cs_q[1];
      sclk_prev <= sclk_q[1];
    end
  end

  assign cs_n_s = cs_q[1];
  assign mosi_s = mosi_q[1];
  assign rise   = sclk_q[1] & ~sclk_prev;
  assign fall   = ~sclk_q[1] & sclk_prev;
  assign start  = cs_prev & ~cs_n_s;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      spi_miso <= 1'b0;
      wr_rdn   <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      we       <= 1'b0;
      err_flag <= 1'b0;
      cnt      <= '0;
      cmd_sh   <= '0;
      data_sh  <= '0;
      miso_sh  <= '0;
      is_wr    <= 1'b0;
    end else if (!ena) begin
      state    <= IDLE;
      spi_miso <= 1'b0;
      if (we && ack) we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          if (we && ack) we <= 1'b0;
          else if (start && !we) begin
            err_flag <= 1'b0;
            cnt      <= '0;
            cmd_sh   <= '0;
            data_sh  <= '0;
            miso_sh  <= '0;
            state    <= CMD;
          end
        end
        CMD: begin
          if (cs_n_s) begin
            err_flag <= 1'b1;
            state    <= IDLE;
          end else if (rise) begin
            cmd_sh <= {cmd_sh[ADDR_W-2:0], mosi_s};
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(ADDR_W)) begin
              is_wr <= cmd_sh[ADDR_W-1];
              addr  <= {cmd_sh[ADDR_W-2:0], mosi_s};
              cnt   <= '0;
              if (cmd_sh[ADDR_W-1]) state <= DATA;
              else begin
                we     <= 1'b1;
                wr_rdn <= 1'b0;
                state  <= RD_REQ;
              end
            end
          end
        end
        RD_REQ: begin
          if (we && ack) begin
            we <= 1'b0;
            if (err) err_flag <= 1'b1;
            if (cs_n_s) begin
              err_flag <= 1'b1;
              state    <= IDLE;
            end else begin
              miso_sh  <= err ? '0 : rdata[REG_W-2:0];
              spi_miso <= err ? 1'b0 : rdata[REG_W-1];
              state    <= DATA;
            end
          end else if (cs_n_s) begin
            err_flag <= 1'b1;  // aborted, but we is held until the bank acks
          end else if (fall) begin
            we       <= 1'b0;
            err_flag <= 1'b1;
            miso_sh  <= '0;
            spi_miso <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (cs_n_s) begin
            err_flag <= 1'b1;
            spi_miso <= 1'b0;
            state    <= IDLE;
          end else begin
            // The fall before the first data rise must not shift: MSB is still on the wire.
            if (fall && !is_wr && cnt != '0) begin
              miso_sh  <= {miso_sh[REG_W-3:0], 1'b0};
              spi_miso <= miso_sh[REG_W-2];
            end
            if (rise) begin
              data_sh <= {data_sh[REG_W-3:0], mosi_s};
              cnt     <= cnt + 1'b1;
              if (cnt == CNT_W'(REG_W - 1)) begin
                spi_miso <= 1'b0;
                if (is_wr) begin
                  wdata  <= {data_sh, mosi_s};
                  wr_rdn <= 1'b1;
                  we     <= 1'b1;
                  state  <= WR_REQ;
                end else begin
                  state <= DONE;
                end
              end
            end
          end
        end
        WR_REQ: begin
          if (ack) begin
            we <= 1'b0;
            if (err) err_flag <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          spi_miso <= 1'b0;
          if (cs_n_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_if.sv
// Randomised SPI-master bench for spi_reg_if with a bank model and a
// request scoreboard checked by an independent monitor.
module tb_spi_reg_if;
  logic       clk = 1'b0, rstb = 1'b0, ena = 1'b1;
  logic       cs_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic       spi_miso, wr_rdn, we, err_flag, ack, err;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;

  int errors = 0, checks = 0;
  int ack_dly = 0;
  bit err_val = 1'b0;
  int wcnt;
  bit bank_init = 1'b0;
  logic [7:0] bank_mem [128];
  logic [7:0] model_mem [128];

  typedef struct {bit wr; logic [6:0] a; logic [7:0] d; int len;} req_t;
  req_t exp_q[$];

  spi_reg_if #(.ADDR_W(7), .REG_W(8)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .spi_cs_n(cs_n), .spi_sclk(sclk),
    .spi_mosi(mosi), .spi_miso(spi_miso), .wr_rdn(wr_rdn), .addr(addr),
    .wdata(wdata), .we(we), .rdata(rdata), .ack(ack), .err(err),
    .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  // Bank: ack either tied high or raised after we has been high ack_dly cycles.
  assign ack   = (ack_dly == 0) ? 1'b1 : (we && wcnt >= ack_dly);
  assign err   = err_val & ack;
  assign rdata = bank_mem[addr];

  always @(posedge clk or negedge rstb)
    if (!rstb) wcnt <= 0;
    else       wcnt <= we ? wcnt + 1 : 0;

  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 128; i++) bank_mem[i] <= 8'(i * 37 + 5);
      bank_init <= 1'b1;
    end else if (rstb && we && ack && wr_rdn && !err) begin
      bank_mem[addr] <= wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted request pops one expected entry.
  initial begin
    logic [6:0] r_a;
    logic [7:0] r_d;
    bit r_wr, stable, we_d;
    int len;
    req_t e;
    we_d = 0; len = 0; stable = 1; r_a = '0; r_d = '0; r_wr = 0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        we_d = 0;
      end else begin
        if (we) begin
          if (!we_d) begin
            r_a = addr; r_d = wdata; r_wr = wr_rdn; stable = 1; len = 0;
          end
          len++;
          if (addr !== r_a || wdata !== r_d || wr_rdn !== r_wr) stable = 0;
          if (ack) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_req: got addr=%0h wr=%0b, expected no request", addr, wr_rdn);
            end else begin
              e = exp_q.pop_front();
              chk("req_wr_rdn", wr_rdn, e.wr);
              chk("req_addr", addr, e.a);
              if (e.wr) chk("req_wdata", wdata, e.d);
              chk("we_len", len, e.len);
              chk("req_stable", stable, 1);
            end
          end
        end
        we_d = we;
      end
    end
  end

  task automatic spi_frame(input logic [15:0] bits, input int nbits, output logic [7:0] mi);
    mi = '0;
    @(negedge clk); cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[15 - i];
      repeat (8) @(negedge clk);
      if (i >= 8) mi = {mi[6:0], spi_miso};
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] mi;
    model_mem[a] = d;
    exp_q.push_back('{1'b1, a, d, ack_dly + 1});
    spi_frame({1'b1, a, d}, 16, mi);
    chk("wr_err_flag", err_flag, 0);
  endtask

  task automatic do_read(input logic [6:0] a, input bit exp_err, input bit exp_req);
    logic [7:0] mi;
    if (exp_req) exp_q.push_back('{1'b0, a, 8'h00, ack_dly + 1});
    spi_frame({1'b0, a, 8'h00}, 16, mi);
    chk("rd_miso", mi, exp_err ? 8'h00 : model_mem[a]);
    chk("rd_err_flag", err_flag, exp_err);
  endtask

  initial begin
    logic [7:0] mi;
    int n;
    for (int i = 0; i < 128; i++) model_mem[i] = 8'(i * 37 + 5);
    repeat (3) @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_wr_rdn", wr_rdn, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    do_write(7'h05, 8'hA5);
    do_write(7'h13, 8'h3C);
    do_read(7'h13, 0, 1);

    ack_dly = 5;
    do_write(7'h22, 8'h5A);
    ack_dly = 0;
    do_read(7'h22, 0, 1);

    // CS_N released after 10 bits of a write: no request, sticky error
    spi_frame({1'b1, 7'h40, 8'h77}, 10, mi);
    chk("abort_err_flag", err_flag, 1);
    do_write(7'h41, 8'h11);
    do_read(7'h40, 0, 1);

    ack_dly = 40;
    do_read(7'h30, 1, 0);
    ack_dly = 0;
    err_val = 1'b1;
    do_read(7'h31, 1, 1);
    err_val = 1'b0;

    // Reset while a read request is pending
    ack_dly = 40;
    fork
      spi_frame({1'b0, 7'h12, 8'h00}, 16, mi);
      begin
        n = 0;
        while (!we && n < 2000) begin @(negedge clk); n++; end
        chk("rst_we_seen", we, 1);
        rstb = 1'b0;
        #1;
        chk("async_rst_we", we, 0);
        chk("async_rst_miso", spi_miso, 0);
        chk("async_rst_err_flag", err_flag, 0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
      end
    join
    ack_dly = 0;
    do_write(7'h12, 8'h99);
    do_read(7'h12, 0, 1);

    for (int k = 0; k < 24; k++) begin
      logic [6:0] a;
      logic [7:0] d;
      a = 7'($urandom);
      d = 8'($urandom);
      ack_dly = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else                           do_read(a, 0, 1);
    end

    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_reg_if.md
Name: spi_reg_if

Overview:
- SPI peripheral front end, mode 0 (CPOL=0, CPHA=0), MSB first. Sits directly upstream of the register bank.
- Decodes one command frame per CS_N assertion into a single read or write request on the bank's application interface.
- Returns read data on MISO within the same frame.
- All SPI pins are asynchronous to clk and are oversampled.

Parameters:
- ADDR_W, 7, register address width. Equals the bank ADDR_W.
- REG_W, 8, register data width. Equals the bank REG_W.

Ports:
- clk  in  1  system clock
- rstb  in  1  reset; asynchronous assert, active-low
- ena  in  1  block enable; low holds the block in IDLE
- spi_cs_n  in  1  SPI chip select, active-low, asynchronous
- spi_sclk  in  1  SPI clock, asynchronous, frequency ≤ clk/8
- spi_mosi  in  1  SPI data in
- spi_miso  out  1  SPI data out, registered
- wr_rdn  out  1  request direction; 1=write, 0=read
- addr  out  ADDR_W  request address
- wdata  out  REG_W  write data
- we  out  1  request valid, held until ack
- rdata  in  REG_W  read data, valid when ack=1 and wr_rdn=0
- ack  in  1  request accepted/completed; may be tied high
- err  in  1  bank error, qualified by ack
- err_flag  out  1  sticky frame error; cleared at next frame start

Behaviour:
- Reset (rstb=0), asynchronous: all outputs are 0; FSM is IDLE; shift registers are 0.
- Input synchronisation: 2-FF synchronisers on spi_cs_n, spi_sclk and spi_mosi.
- SCLK edge detection: rise = sync==1 && prev==0; fall = opposite.
- Frame format, MSB first, total 1+ADDR_W+REG_W bits (16 at defaults):
  - bit 0: W (1=write)
  - next ADDR_W bits: address
  - next REG_W bits: data (MOSI for write; MISO for read)
- Frame start: synced CS_N falling edge. Effects: clears err_flag, bit counter and shift registers; moves to CMD.
- FSM states:
  - IDLE: wait for frame start while ena=1.
  - CMD: shift MOSI on each SCLK rise. After bit 1+ADDR_W, latch W and addr. If W=0 go to RD_REQ, else go to DATA.
  - RD_REQ: we=1, wr_rdn=0 from the next clk. On ack: load rdata into the MISO shifter, we=0, go to DATA.
    - If err=1 with ack: load 0 instead of rdata, set err_flag.
    - If no ack before the next synced SCLK fall: set err_flag, we=0, MISO shifts zeros, go to DATA.
  - DATA: read frames shift MISO out on each SCLK fall, MSB first. Write frames shift MOSI in on each SCLK rise. After REG_W bits: write goes to WR_REQ, read goes to DONE.
  - WR_REQ: we=1, wr_rdn=1, wdata=shifted byte from the next clk. we stays high until ack sampled 1, then drops to 0 and the FSM goes to DONE. err=1 with ack sets err_flag. No timeout.
  - DONE: ignore SCLK. spi_miso=0. Wait for CS_N high, then go to IDLE.
- Request ordering: addr/wr_rdn/wdata are stable while we=1. we is high for exactly one cycle when ack is already high (tied-high bank).
- spi_miso: 0 outside the read data phase.
- MISO timing: first data bit (MSB) is driven right after the read ack, before the first data SCLK rise. Each following bit is driven on a synced SCLK fall.
- CS_N deasserted mid-frame (before the data phase completes):
  - Frame is discarded; no write request is issued.
  - A request already in flight (we=1) is held until ack, then the FSM goes to IDLE.
  - err_flag is set.
- Extra SCLK edges after a full frame: ignored (DONE).
- ena=0: FSM forced to IDLE on the next clk. we drops only after a pending ack. SPI inputs are ignored; spi_miso=0.

Test Plan:
- Write frame 1_0000101_10100101 (W=1, addr=0x05, data=0xA5), ack tied 1 -> exactly one cycle with we=1, wr_rdn=1, addr=0x05, wdata=0xA5; err_flag=0.
- Read frame 0_0010011, rdata=0x3C, ack tied 1 -> one-cycle we=1, wr_rdn=0, addr=0x13; MISO sampled on SCLK rises of the data phase = 0x3C.
- Write with ack delayed 5 clk -> we stays 1 for 6 cycles with addr/wdata stable; FSM reaches DONE after ack.
- CS_N released after 10 bits of a write -> we never asserts; err_flag=1. Next frame start clears err_flag to 0.
- Read with ack delayed past the first data SCLK fall -> err_flag=1, MISO reads 0x00. Read with err=1 and ack=1 -> err_flag=1, MISO reads 0x00.
- rstb pulsed low mid-frame with we=1 -> we, spi_miso, err_flag drop to 0 immediately. A following full write frame completes normally.
